// File: rtl/mtimer_bank.sv
// mtimer_bank: CLINT-style machine timer and software interrupt bank for up to 8 harts
module mtimer_bank #(
  parameter int NUM_HARTS = 1,
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic req_valid_i,
  input  logic req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic time_en_i,
  output logic hit_o,
  output logic err_o,
  output logic [31:0] rdata_o,
  output logic [NUM_HARTS-1:0] timer_irq_o,
  output logic [NUM_HARTS-1:0] soft_irq_o,
  output logic [63:0] mtime_o
);
  logic [31:0] offset;
  logic [15:0] off;
  logic ok, wr, wr_lo, wr_hi, tick;
  logic [63:0] mtime, mtime_n;
  logic [15:0] pre, pre_n;
  logic [63:0] cmp [NUM_HARTS];
  logic [63:0] cmp_n [NUM_HARTS];
  logic [NUM_HARTS-1:0] msip, msip_n, irq;
  assign offset = req_addr_i - BASE_ADDR;
  assign hit_o = req_valid_i && req_addr_i >= BASE_ADDR && offset[31:16] == 16'h0;
  assign off = offset[15:0];
  assign err_o = hit_o && off[1:0] != 2'b00;
  assign ok = hit_o && !err_o;
  assign wr = ok && req_we_i;
  assign wr_lo = wr && off == 16'hBFF8;
  assign wr_hi = wr && off == 16'hBFFC;
  assign tick = time_en_i && pre == 16'(PRESCALE - 1);
  assign timer_irq_o = irq;
  assign soft_irq_o = msip;
  assign mtime_o = mtime;
  // load data from the pre-edge register values; unmapped or misaligned reads give 0
  always_comb begin
    rdata_o = '0;
    if (ok) begin
      rdata_o = off == 16'hBFF8 ? mtime[31:0] : off == 16'hBFFC ? mtime[63:32] : 32'h0;
      for (int h = 0; h < NUM_HARTS; h++) begin
        if (off[15:14] == 2'b00 && off[13:2] == 12'(h)) rdata_o = {31'b0, msip[h]};
        if (off[15:14] == 2'b01 && off[13:3] == 11'(h)) rdata_o = off[2] ? cmp[h][63:32] : cmp[h][31:0];
      end
    end
  end
  // store decode and timebase: an mtime store beats the increment and restarts the prescaler
  always_comb begin
    msip_n = msip;
    cmp_n = cmp;
    for (int h = 0; h < NUM_HARTS; h++) begin
      if (wr && off[15:14] == 2'b00 && off[13:2] == 12'(h)) msip_n[h] = req_wdata_i[0];
      if (wr && off[15:14] == 2'b01 && off[13:3] == 11'(h) && off[2]) cmp_n[h][63:32] = req_wdata_i;
      if (wr && off[15:14] == 2'b01 && off[13:3] == 11'(h) && !off[2]) cmp_n[h][31:0] = req_wdata_i;
    end
    mtime_n = wr_lo ? {mtime[63:32], req_wdata_i} : wr_hi ? {req_wdata_i, mtime[31:0]} : tick ? mtime + 64'd1 : mtime;
    pre_n = (wr_lo || wr_hi || tick) ? 16'h0 : time_en_i ? pre + 16'd1 : pre;
  end
  // state registers; the interrupt compares the values settled by the previous edge
  always_ff @(posedge clk) begin
    if (rst) begin
      mtime <= '0;
      pre <= '0;
      msip <= '0;
      irq <= '0;
      for (int h = 0; h < NUM_HARTS; h++) cmp[h] <= '1;
    end else begin
      mtime <= mtime_n;
      pre <= pre_n;
      msip <= msip_n;
      for (int h = 0; h < NUM_HARTS; h++) begin
        cmp[h] <= cmp_n[h];
        irq[h] <= mtime >= cmp[h];
      end
    end
  end
endmodule
